// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_rd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } rd_state_e;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned RD_LATENCY = 1;
    // Reads in flight plus buffered words may never exceed what the FIFO can absorb.
    localparam int unsigned CREDIT_LIMIT = FIFO_DEPTH + RD_LATENCY - 1;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream with a last flag.
interface ram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/reader_skid_fifo.sv
// Two-entry FIFO holding returned RAM words plus their last flag.
module reader_skid_fifo #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader for a 1-cycle-latency synchronous RAM, streaming words out with valid/ready/last.
// Optional READ_CHECKSUM_EN adds a running XOR of the handshaked words of the current burst.
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    ram_stream_reader_if.master   m
`ifdef READ_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    rd_state_e             state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic                  rd_pend_q;
    logic                  rd_last_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  pop;
    logic                  issue;
    logic                  issue_last;
    logic [1:0]            occ;
    logic [2:0]            used;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_rdata;

    // A word leaving this cycle frees its slot in time for a read issued now.
    always_comb begin
        pop        = m.valid & m.ready;
        occ        = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
        used       = {2'b00, rd_pend_q} + {1'b0, occ} - {2'b00, pop};
        issue      = (state_q == StIssue) && (used < 3'(CREDIT_LIMIT));
        issue_last = issue && (issued_q == len_q - LEN_WIDTH'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rd_pend_q <= issue;
            rd_last_q <= issue_last;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len != '0) begin
                            state_q  <= StIssue;
                            addr_q   <= base_addr;
                            len_q    <= len;
                            issued_q <= '0;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (issue) begin
                        addr_q   <= addr_q + ADDR_WIDTH'(1);
                        issued_q <= issued_q + LEN_WIDTH'(1);
                        if (issue_last) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && m.last) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    reader_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend_q),
        .wdata ({rd_last_q, ram_dout}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m.data   = fifo_rdata[DATA_WIDTH-1:0];
    assign m.last   = fifo_rdata[DATA_WIDTH];
    assign m.valid  = ~fifo_empty;
    assign ram_addr = addr_q;
    assign ram_we   = 1'b0;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef READ_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (state_q == StIdle && start) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum ^ m.data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural 16x64 synchronous-read RAM.
module tb_ram_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  len = '0;
    logic        busy;
    logic        done;
    logic [3:0]  ram_addr;
    logic        ram_we;
    logic [63:0] ram_dout = '0;
    logic [63:0] mem [16];
`ifdef READ_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    int passes = 0;
    int total  = 0;

    ram_stream_reader_if #(.DATA_WIDTH(64)) s ();

    ram_stream_reader #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (64),
        .LEN_WIDTH  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .m         (s)
`ifdef READ_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= mem[ram_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst; checks order, last flag, stall stability and the done pulse.
    task automatic burst(input string tag, input logic [3:0] b, input logic [4:0] n,
                         input logic [15:0] rpat, input bit full_rate, input int restart_at);
        int          idx;
        int          cyc;
        int          first;
        bit          stalled;
        logic [63:0] held_data;
        logic        held_last;
        logic [3:0]  a;
        idx = 0; cyc = 0; first = -1; stalled = 0; held_data = '0; held_last = 0;
        base_addr = b; len = n; start = 1'b1;
        step();
        start = 1'b0;
        while (idx < int'(n) && cyc < 100) begin
            s.ready = rpat[cyc % 16];
            if (cyc == restart_at) begin
                start = 1'b1; base_addr = 4'd5; len = 5'd2;
            end else begin
                start = 1'b0;
            end
            if (cyc == 0) chk({tag, " busy"}, 64'(busy), 64'd1);
            if (full_rate && cyc < int'(n)) begin
                a = b + 4'(cyc);
                chk({tag, " ram_addr"}, 64'(ram_addr), 64'(a));
            end
            if (stalled) begin
                chk({tag, " stall valid"}, 64'(s.valid), 64'd1);
                chk({tag, " stall data"}, s.data, held_data);
                chk({tag, " stall last"}, 64'(s.last), 64'(held_last));
            end
            if (s.valid) begin
                if (first < 0) first = cyc;
                if (s.ready) begin
                    a = b + 4'(idx);
                    chk({tag, " data"}, s.data, mem[a]);
                    chk({tag, " last"}, 64'(s.last), 64'(idx == int'(n) - 1));
                    idx++;
                end
            end
            stalled   = s.valid && !s.ready;
            held_data = s.data;
            held_last = s.last;
            step();
            cyc++;
        end
        start = 1'b0;
        chk({tag, " word count"}, 64'(idx), 64'(n));
        if (full_rate) begin
            chk({tag, " first valid cycle"}, 64'(first), 64'd2);
            chk({tag, " no bubbles"}, 64'(cyc), 64'(int'(n) + 2));
        end
        chk({tag, " done pulse"}, 64'(done), 64'd1);
        chk({tag, " busy off"}, 64'(busy), 64'd0);
        step();
        chk({tag, " done drop"}, 64'(done), 64'd0);
        chk({tag, " valid idle"}, 64'(s.valid), 64'd0);
    endtask

    initial begin
        int got;
        for (int i = 0; i < 16; i++) mem[i] = 64'(i * 3);
        s.ready = 1'b0;
        step(); step();
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst ram_addr", 64'(ram_addr), 64'd0);
        chk("rst valid", 64'(s.valid), 64'd0);
        chk("rst last", 64'(s.last), 64'd0);
        chk("rst data", s.data, 64'd0);
        chk("ram_we", 64'(ram_we), 64'd0);
        rst = 1'b0;
        step();

        // Full-rate: expect 6,9,12,15,18
        burst("full", 4'd2, 5'd5, 16'hFFFF, 1'b1, -1);
        // Wrap-around: addresses 14,15,0,1
        burst("wrap", 4'd14, 5'd4, 16'hFFFF, 1'b1, -1);
        // Backpressure, ready 1,0,0,1,0,1,... (bit i = cycle i)
        burst("bp", 4'd3, 5'd6, 16'b1010_0101_1010_1001, 1'b0, -1);

        // Zero length: address stays at 3+6 = 9
        base_addr = 4'd5; len = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("zero done", 64'(done), 64'd1);
        chk("zero ram_addr", 64'(ram_addr), 64'd9);
        chk("zero valid", 64'(s.valid), 64'd0);
        step();
        chk("zero done drop", 64'(done), 64'd0);
        chk("zero valid2", 64'(s.valid), 64'd0);
        chk("zero ram_addr2", 64'(ram_addr), 64'd9);

        // Reset after the 2nd of 8 words
        s.ready = 1'b1; base_addr = 4'd0; len = 5'd8; start = 1'b1;
        step();
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (s.valid) got++;
            step();
        end
        chk("mid words", 64'(got), 64'd2);
        chk("mid busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async busy", 64'(busy), 64'd0);
        chk("async ram_addr", 64'(ram_addr), 64'd0);
        chk("async valid", 64'(s.valid), 64'd0);
        chk("async last", 64'(s.last), 64'd0);
        chk("async data", s.data, 64'd0);
        step();
        chk("async done", 64'(done), 64'd0);
        rst = 1'b0;
        step();
        burst("post rst", 4'd0, 5'd3, 16'hFFFF, 1'b1, -1);

        // Start mid-burst is ignored
        burst("restart", 4'd4, 5'd4, 16'hFFFF, 1'b1, 1);

        // Checksum words 1,2,4
        mem[8] = 64'h1; mem[9] = 64'h2; mem[10] = 64'h4;
        burst("csum", 4'd8, 5'd3, 16'hFFFF, 1'b1, -1);
`ifdef READ_CHECKSUM_EN
        chk("checksum hold", checksum, 64'h7);
        step();
        chk("checksum hold2", checksum, 64'h7);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
